// File: rtl/axis_mash11_dsm.sv
// ---------------------------------------------------------------------------
// axis_mash11_dsm
//
// Second-order MASH 1-1 delta-sigma modulator. PCM samples arrive over
// AXI-Stream and each one is held for osr+1 modulator steps. Two cascaded
// first-order error-feedback accumulators run on every step. Their carries
// are combined into a 3-bit noise-shaped code in the range -1..+2.
//
// Ports:
//   aclk                system clock, rising edge
//   arst                asynchronous reset, active high
//   osr                 hold interval minus one, sampled at reload ticks
//   s_axis_data_tdata   signed PCM sample
//   s_axis_data_tvalid  sample valid
//   s_axis_data_tready  pend register empty, or being emptied this cycle
//   m_axis_data_tdata   signed modulator code (-1..+2)
//   m_axis_data_tvalid  high on every cycle that carries a code
//   underrun            sticky: a reload tick found no pending sample
// ---------------------------------------------------------------------------
module axis_mash11_dsm #(
    parameter int WIDTH = 16,
    parameter int OSR_W = 8
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [OSR_W-1:0] osr,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [2:0]       m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    output logic             underrun
);

    // Input buffering and hold-interval control
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] x_cur_q, x_cur_d;
    logic [OSR_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             underrun_q, underrun_d;

    // Modulator state
    logic [WIDTH-1:0] acc1_q, acc1_d;
    logic [WIDTH-1:0] acc2_q, acc2_d;
    logic             c2_d_q, c2_d_d;
    logic [2:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;

    logic             reload;
    logic             hs;
    logic [WIDTH-1:0] xu;
    logic [WIDTH:0]   sum1;
    logic [WIDTH:0]   sum2;
    logic [2:0]       y;

    // Before the first sample arrives, the reload is triggered by the pend
    // register filling up. After that, the hold counter paces reloads.
    assign reload             = running_q ? (cnt_q == '0) : pend_valid_q;
    assign s_axis_data_tready = !pend_valid_q || reload;
    assign hs                 = s_axis_data_tvalid && s_axis_data_tready;

    // Flipping the sign bit maps signed -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
    assign xu   = {~x_cur_q[WIDTH-1], x_cur_q[WIDTH-2:0]};
    assign sum1 = {1'b0, acc1_q} + {1'b0, xu};
    // Stage 2 integrates the updated stage-1 residue, not the old acc1.
    assign sum2 = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};
    // y = c1 + c2 - c2(prev). This is evaluated modulo 8, so -1 wraps to 3'b111.
    assign y    = {2'b00, sum1[WIDTH]} + {2'b00, sum2[WIDTH]} - {2'b00, c2_d_q};

    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        x_cur_d      = x_cur_q;
        cnt_d        = cnt_q;
        running_d    = running_q;
        underrun_d   = underrun_q;

        if (hs) begin
            pend_d       = s_axis_data_tdata;
            pend_valid_d = 1'b1;
        end

        if (reload) begin
            cnt_d     = osr;
            running_d = 1'b1;
            if (pend_valid_q) begin
                x_cur_d = pend_q;
                // A same-cycle handshake refills pend, so it stays valid.
                if (!hs) pend_valid_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (running_q) begin
            cnt_d = cnt_q - OSR_W'(1);
        end
    end

    always_comb begin
        acc1_d   = acc1_q;
        acc2_d   = acc2_q;
        c2_d_d   = c2_d_q;
        tdata_d  = 3'b000;
        tvalid_d = 1'b0;
        // The step in a reload cycle still sees the old x_cur.
        if (running_q) begin
            acc1_d   = sum1[WIDTH-1:0];
            acc2_d   = sum2[WIDTH-1:0];
            c2_d_d   = sum2[WIDTH];
            tdata_d  = y;
            tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            x_cur_q      <= '0;
            cnt_q        <= '0;
            running_q    <= 1'b0;
            underrun_q   <= 1'b0;
            acc1_q       <= '0;
            acc2_q       <= '0;
            c2_d_q       <= 1'b0;
            tdata_q      <= 3'b000;
            tvalid_q     <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            x_cur_q      <= x_cur_d;
            cnt_q        <= cnt_d;
            running_q    <= running_d;
            underrun_q   <= underrun_d;
            acc1_q       <= acc1_d;
            acc2_q       <= acc2_d;
            c2_d_q       <= c2_d_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;
    assign underrun           = underrun_q;

endmodule

// File: tb/tb_axis_mash11_dsm.sv
// Testbench for axis_mash11_dsm. Samples are queued up front and tvalid is
// held high until the queue drains. Output step n therefore uses sample
// n/(osr+1), or the last sample once the queue has run dry. The reference
// model computes the MASH 1-1 output from that rule using integer arithmetic.
module tb_axis_mash11_dsm;
    logic        aclk = 1'b0;
    logic        arst;
    logic [7:0]  osr;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [2:0]  m_tdata;
    logic        m_tvalid;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] samp[$];
    int          outs[$];
    int          exp_q[$];
    int          hs_cyc[$];
    int          rdy_cnt;
    int          vld_first;

    axis_mash11_dsm #(.WIDTH(16), .OSR_W(8)) dut (
        .aclk(aclk), .arst(arst), .osr(osr),
        .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
        .underrun(underrun)
    );

    always #5 aclk = ~aclk;

    // Reference model: step n uses sample min(n/(osr+1), last).
    task automatic build_expected(input int osr_v, input int n_steps);
        longint a1 = 0, a2 = 0;
        int c1, c2, c2p = 0, idx, xu;
        exp_q.delete();
        for (int n = 0; n < n_steps; n++) begin
            idx = n / (osr_v + 1);
            if (idx > samp.size() - 1) idx = samp.size() - 1;
            xu = int'($signed(samp[idx])) + 32768;
            a1 = a1 + xu;
            c1 = (a1 >= 65536) ? 1 : 0;
            a1 = a1 % 65536;
            a2 = a2 + a1;
            c2 = (a2 >= 65536) ? 1 : 0;
            a2 = a2 % 65536;
            exp_q.push_back(c1 + c2 - c2p);
            c2p = c2;
        end
    endtask

    // Drives the queued samples with tvalid held high. Starts and ends 1 time
    // unit after a rising edge. Iteration cyc covers the edge numbered cyc.
    task automatic run_stream(input int osr_v, input int n_cycles);
        int idx = 0;
        outs.delete();
        hs_cyc.delete();
        rdy_cnt   = 0;
        vld_first = -1;
        osr = 8'(osr_v);
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            s_tvalid = (idx < samp.size());
            s_tdata  = s_tvalid ? samp[idx] : 16'h0000;
            #1;
            if (s_tready) rdy_cnt++;
            if (s_tvalid && s_tready) begin
                hs_cyc.push_back(cyc);
                idx++;
            end
            @(posedge aclk);
            #1;
            if (m_tvalid) begin
                if (vld_first < 0) vld_first = cyc;
                outs.push_back(int'($signed(m_tdata)));
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; osr = '0;
        repeat (2) @(posedge aclk);
        #1;
        n_tests++;
        if (m_tvalid !== 1'b0 || m_tdata !== 3'b000 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tvalid=%b tdata=%b underrun=%b, need 0/000/0",
                     m_tvalid, m_tdata, underrun);
        end
        arst = 1'b0;
        @(posedge aclk);
        #1;
        n_tests++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready: got tready=%b tvalid=%b, need 1/0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_min_sample();
        int bad = 0;
        samp.delete();
        samp.push_back(16'h8000);
        run_stream(3, 12);
        n_tests++;
        if (vld_first !== 2 || hs_cyc.size() != 1 || hs_cyc[0] != 0) begin
            n_fail++;
            $display("FAIL startup_latency: got first valid at edge %0d, need 2", vld_first);
        end
        foreach (outs[i]) if (outs[i] != 0) bad++;
        n_tests++;
        if (bad != 0 || outs.size() != 10) begin
            n_fail++;
            $display("FAIL min_sample_zero: got %0d nonzero of %0d, need 0 of 10", bad, outs.size());
        end
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL min_underrun: got %b, need 1", underrun);
        end
    endtask

    task automatic test_midscale();
        int pat[4] = '{0, 1, 1, 0};
        int bad = 0, sum = 0;
        samp.delete();
        repeat (40) samp.push_back(16'h0000);
        run_stream(0, 30);
        foreach (outs[i]) begin
            if (outs[i] != pat[i % 4]) bad++;
            sum += outs[i];
        end
        n_tests++;
        if (bad != 0 || outs.size() != 28) begin
            n_fail++;
            $display("FAIL midscale_pattern: got %0d mismatches over %0d outputs, need 0 over 28",
                     bad, outs.size());
        end
        n_tests++;
        if (sum != 14) begin
            n_fail++;
            $display("FAIL midscale_mean: got sum %0d, need 14", sum);
        end
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midscale_underrun: got %b, need 0", underrun);
        end
    endtask

    task automatic test_max_sample();
        int sum = 0, range_bad = 0, bad = 0;
        samp.delete();
        samp.push_back(16'h7FFF);
        run_stream(255, 65538);
        build_expected(255, outs.size());
        foreach (outs[i]) begin
            sum += outs[i];
            if (outs[i] < -1 || outs[i] > 2) range_bad++;
            if (outs[i] != exp_q[i]) bad++;
        end
        n_tests++;
        if (outs.size() != 65536 || sum < 65534 || sum > 65536) begin
            n_fail++;
            $display("FAIL max_sum: got %0d over %0d steps, need 65535+-1 over 65536",
                     sum, outs.size());
        end
        n_tests++;
        if (range_bad != 0) begin
            n_fail++;
            $display("FAIL max_range: got %0d codes outside -1..2, need 0", range_bad);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL max_model: got %0d mismatches vs model, need 0", bad);
        end
    endtask

    task automatic test_flow_osr5();
        int bad_gap = 0, bad = 0;
        samp.delete();
        repeat (20) samp.push_back(16'($urandom));
        run_stream(5, 100);
        for (int k = 2; k < hs_cyc.size(); k++)
            if (hs_cyc[k] - hs_cyc[k-1] != 6) bad_gap++;
        n_tests++;
        if (hs_cyc.size() != 18 || hs_cyc[1] != 1 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL osr5_handshakes: got %0d handshakes, %0d bad gaps, need 18 with gap 6",
                     hs_cyc.size(), bad_gap);
        end
        n_tests++;
        if (rdy_cnt != 18) begin
            n_fail++;
            $display("FAIL osr5_tready: got tready high %0d cycles, need 18", rdy_cnt);
        end
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL osr5_underrun: got %b, need 0", underrun);
        end
        build_expected(5, outs.size());
        foreach (outs[i]) if (outs[i] != exp_q[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL osr5_model: got %0d mismatches, need 0", bad);
        end
    endtask

    // With osr=0, every cycle is a reload while pend is full. Each handshake
    // therefore collides with a reload.
    task automatic test_back_to_back();
        int bad = 0;
        samp.delete();
        repeat (30) samp.push_back(16'($urandom));
        run_stream(0, 28);
        build_expected(0, outs.size());
        foreach (outs[i]) if (outs[i] != exp_q[i]) bad++;
        n_tests++;
        if (bad != 0 || outs.size() != 26 || hs_cyc.size() != 28) begin
            n_fail++;
            $display("FAIL b2b_sequence: got %0d mismatches, %0d outs, %0d hs; need 0/26/28",
                     bad, outs.size(), hs_cyc.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int osr_v, n, ncyc, bad = 0;
            logic exp_u;
            test_reset();
            osr_v = $urandom_range(0, 7);
            n = $urandom_range(3, 12);
            samp.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0: samp.push_back(16'h8000);
                    1: samp.push_back(16'h7FFF);
                    default: samp.push_back(16'($urandom));
                endcase
            end
            ncyc = $urandom_range(10, n * (osr_v + 1) + 15);
            run_stream(osr_v, ncyc);
            build_expected(osr_v, outs.size());
            foreach (outs[i]) if (outs[i] != exp_q[i]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_model[%0d]: got %0d mismatches (osr=%0d), need 0", it, bad, osr_v);
            end
            exp_u = (outs.size() >= n * (osr_v + 1));
            n_tests++;
            if (underrun !== exp_u) begin
                n_fail++;
                $display("FAIL random_underrun[%0d]: got %b, need %b", it, underrun, exp_u);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int bad = 0;
        samp.delete();
        repeat (10) samp.push_back(16'($urandom));
        run_stream(2, 17);
        arst = 1'b1;
        #1;
        n_tests++;
        if (m_tvalid !== 1'b0 || m_tdata !== 3'b000 || s_tready !== 1'b1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got tvalid=%b tdata=%b tready=%b underrun=%b, need 0/000/1/0",
                     m_tvalid, m_tdata, s_tready, underrun);
        end
        @(posedge aclk);
        #1;
        arst = 1'b0;
        samp.delete();
        repeat (8) samp.push_back(16'($urandom));
        run_stream(3, 30);
        build_expected(3, outs.size());
        foreach (outs[i]) if (outs[i] != exp_q[i]) bad++;
        n_tests++;
        if (bad != 0 || vld_first != 2) begin
            n_fail++;
            $display("FAIL midreset_rerun: got %0d mismatches, first valid %0d; need 0 and 2",
                     bad, vld_first);
        end
    endtask

    initial begin
        test_reset();
        test_min_sample();
        test_reset();
        test_midscale();
        test_reset();
        test_max_sample();
        test_reset();
        test_flow_osr5();
        test_reset();
        test_back_to_back();
        test_random();
        test_reset();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
